// File: rtl/gpr_transfer_sequencer_pkg.sv
// Shared definitions for the GPR transfer sequencer: opcodes, GPR select
// codes, ALU op codes, per-opcode step counts and the control word.
// Register select code 001 addresses R7; no current sequence drives it.
package gpr_transfer_sequencer_pkg;

  localparam logic [3:0] OPC_NOP  = 4'd0;
  localparam logic [3:0] OPC_MOV  = 4'd1;
  localparam logic [3:0] OPC_ADD  = 4'd2;
  localparam logic [3:0] OPC_SUB  = 4'd3;
  localparam logic [3:0] OPC_SWAP = 4'd4;
  localparam logic [3:0] OPC_CLR  = 4'd5;

  localparam logic [2:0] SEL_R0  = 3'b000;
  localparam logic [2:0] SEL_RD1 = 3'b010;
  localparam logic [2:0] SEL_RD2 = 3'b011;
  localparam logic [2:0] SEL_RS1 = 3'b100;
  localparam logic [2:0] SEL_RS2 = 3'b101;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_PASS_A = 2'b10;

  typedef enum logic {S_IDLE, S_EXEC} state_t;

  typedef struct packed {
    logic       gpr_in;
    logic       gpr_out;
    logic [2:0] gpr_select;
    logic       tmp_in;
    logic       tmp_out;
    logic       alu_a_in;
    logic       alu_b_in;
    logic       alu_out;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Number of bus micro-steps per opcode; undefined opcodes behave as NOP.
  function automatic logic [2:0] op_steps(input logic [3:0] opc);
    case (opc)
      OPC_NOP:          op_steps = 3'd0;
      OPC_MOV, OPC_CLR: op_steps = 3'd2;
      OPC_ADD, OPC_SUB: op_steps = 3'd3;
      OPC_SWAP:         op_steps = 3'd4;
      default:          op_steps = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/gpr_transfer_sequencer_uop_rom.sv
// Micro-op ROM: combinational (opcode, step) -> control word and last-step flag.
module gpr_uop_rom
  import gpr_transfer_sequencer_pkg::*;
#(
  parameter int OPC_W  = 4,
  parameter int STEP_W = 2
) (
  input  logic [OPC_W-1:0]  opcode,
  input  logic [STEP_W-1:0] step,
  output ctrl_t             ctrl,
  output logic              last
);

  // Decode one bus transfer per step; the destination captures at the closing edge.
  always_comb begin
    ctrl = CTRL_IDLE;
    last = ((int'(step) + 1) == int'(op_steps(opcode)));
    case (opcode)
      OPC_MOV, OPC_CLR: begin
        case (int'(step))
          0: begin
            ctrl.gpr_out    = 1'b1;
            ctrl.gpr_select = (opcode == OPC_CLR) ? SEL_R0 : SEL_RS1;
            ctrl.tmp_in     = 1'b1;
          end
          1: begin
            ctrl.tmp_out    = 1'b1;
            ctrl.gpr_in     = 1'b1;
            ctrl.gpr_select = SEL_RD1;
          end
          default: ;
        endcase
      end
      OPC_ADD, OPC_SUB: begin
        case (int'(step))
          0: begin
            ctrl.gpr_out    = 1'b1;
            ctrl.gpr_select = SEL_RS1;
            ctrl.alu_a_in   = 1'b1;
          end
          1: begin
            ctrl.gpr_out    = 1'b1;
            ctrl.gpr_select = SEL_RS2;
            ctrl.alu_b_in   = 1'b1;
          end
          2: begin
            ctrl.alu_out    = 1'b1;
            ctrl.alu_op     = (opcode == OPC_SUB) ? ALU_SUB : ALU_ADD;
            ctrl.gpr_in     = 1'b1;
            ctrl.gpr_select = SEL_RD1;
          end
          default: ;
        endcase
      end
      OPC_SWAP: begin
        // Rd_2 is parked in ALU A so Rd_1 == Rd_2 still restores the original value.
        case (int'(step))
          0: begin
            ctrl.gpr_out    = 1'b1;
            ctrl.gpr_select = SEL_RD1;
            ctrl.tmp_in     = 1'b1;
          end
          1: begin
            ctrl.gpr_out    = 1'b1;
            ctrl.gpr_select = SEL_RD2;
            ctrl.alu_a_in   = 1'b1;
          end
          2: begin
            ctrl.tmp_out    = 1'b1;
            ctrl.gpr_in     = 1'b1;
            ctrl.gpr_select = SEL_RD2;
          end
          3: begin
            ctrl.alu_out    = 1'b1;
            ctrl.alu_op     = ALU_PASS_A;
            ctrl.gpr_in     = 1'b1;
            ctrl.gpr_select = SEL_RD1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/gpr_transfer_sequencer.sv
// GPR transfer sequencer: IDLE/EXEC FSM, step counter and instruction field
// latches; control strobes come from gpr_uop_rom.
// Optional build macro ILLEGAL_OP_TRAP_EN enables the sticky illegal_op flag.
module gpr_transfer_sequencer
  import gpr_transfer_sequencer_pkg::*;
#(
  parameter int OPC_W         = 4,
  parameter int NUM_STEPS_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] instr,
  output logic        busy,
  output logic        done,
  output logic        GPR_in,
  output logic        GPR_out,
  output logic [2:0]  GPR_select,
  output logic [2:0]  Rd_1,
  output logic [2:0]  Rd_2,
  output logic [2:0]  Rs_1,
  output logic [2:0]  Rs_2,
  output logic        TMP_in,
  output logic        TMP_out,
  output logic        ALU_A_in,
  output logic        ALU_B_in,
  output logic        ALU_out,
  output logic [1:0]  ALU_op,
  output logic        illegal_op
);

  localparam int STEP_W = (NUM_STEPS_MAX > 1) ? $clog2(NUM_STEPS_MAX) : 1;

  state_t             state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [OPC_W-1:0]   opc_q, opc_d;
  logic [2:0]         rd1_q, rd1_d, rd2_q, rd2_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic               done_q, done_d;
  logic               accept;
  ctrl_t              rom_ctrl, ctrl;
  logic               rom_last;

  assign accept = (state_q == S_IDLE) && start;

  gpr_uop_rom #(.OPC_W(OPC_W), .STEP_W(STEP_W)) u_rom (
    .opcode (opc_q),
    .step   (step_q),
    .ctrl   (rom_ctrl),
    .last   (rom_last)
  );

  // State register: FSM, step counter, latched fields and done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      opc_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      opc_q   <= opc_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      done_q  <= done_d;
    end
  end

  // Next state: accept in IDLE, walk the steps, pulse done after the last one.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    opc_d   = opc_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          opc_d  = instr[15:16-OPC_W];
          rd1_d  = instr[11:9];
          rd2_d  = instr[8:6];
          rs1_d  = instr[5:3];
          rs2_d  = instr[2:0];
          step_d = '0;
          if (op_steps(instr[15:16-OPC_W]) == 3'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (rom_last) begin
          state_d = S_IDLE;
          step_d  = '0;
          done_d  = 1'b1;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: strobes only while executing, decoded from registered state.
  always_comb begin
    ctrl = CTRL_IDLE;
    if (state_q == S_EXEC) begin
      ctrl = rom_ctrl;
    end
  end

  assign busy       = (state_q == S_EXEC);
  assign done       = done_q;
  assign GPR_in     = ctrl.gpr_in;
  assign GPR_out    = ctrl.gpr_out;
  assign GPR_select = ctrl.gpr_select;
  assign TMP_in     = ctrl.tmp_in;
  assign TMP_out    = ctrl.tmp_out;
  assign ALU_A_in   = ctrl.alu_a_in;
  assign ALU_B_in   = ctrl.alu_b_in;
  assign ALU_out    = ctrl.alu_out;
  assign ALU_op     = ctrl.alu_op;
  assign Rd_1       = rd1_q;
  assign Rd_2       = rd2_q;
  assign Rs_1       = rs1_q;
  assign Rs_2       = rs2_q;

`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_q, illegal_d;

  // Sticky trap: set on acceptance of any undefined opcode.
  always_comb begin
    illegal_d = illegal_q;
    if (accept && (instr[15:12] > OPC_CLR)) begin
      illegal_d = 1'b1;
    end
  end

  // Trap flag register, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end

  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_gpr_transfer_sequencer.sv
// Self-checking bench for gpr_transfer_sequencer: a queue holds the expected
// per-cycle output word; a negedge monitor pops and compares every cycle.
module tb_gpr_transfer_sequencer;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       gin;
    logic       gout;
    logic [2:0] sel;
    logic       tin;
    logic       tout;
    logic       ain;
    logic       bin;
    logic       aout;
    logic [1:0] op;
  } rec_t;

`ifdef ILLEGAL_OP_TRAP_EN
  localparam logic EXP_ILL = 1'b1;
`else
  localparam logic EXP_ILL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] instr;
  logic        busy, done, GPR_in, GPR_out, TMP_in, TMP_out;
  logic        ALU_A_in, ALU_B_in, ALU_out, illegal_op;
  logic [2:0]  GPR_select, Rd_1, Rd_2, Rs_1, Rs_2;
  logic [1:0]  ALU_op;

  int   total = 0;
  int   bad   = 0;
  rec_t exp_q[$];
  rec_t mon_obs, mon_exp;

  gpr_transfer_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr),
    .busy(busy), .done(done), .GPR_in(GPR_in), .GPR_out(GPR_out),
    .GPR_select(GPR_select), .Rd_1(Rd_1), .Rd_2(Rd_2), .Rs_1(Rs_1), .Rs_2(Rs_2),
    .TMP_in(TMP_in), .TMP_out(TMP_out), .ALU_A_in(ALU_A_in), .ALU_B_in(ALU_B_in),
    .ALU_out(ALU_out), .ALU_op(ALU_op), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t mk(input logic gin, input logic gout, input logic [2:0] sel,
                              input logic tin, input logic tout, input logic ain,
                              input logic bin, input logic aout, input logic [1:0] op);
    rec_t r;
    r = '0;
    r.busy = 1'b1;
    r.gin = gin; r.gout = gout; r.sel = sel; r.tin = tin; r.tout = tout;
    r.ain = ain; r.bin = bin; r.aout = aout; r.op = op;
    return r;
  endfunction

  // Expected step-by-step outputs after acceptance, followed by the done cycle.
  task automatic expect_instr(input logic [15:0] ins);
    rec_t d;
    case (ins[15:12])
      4'd1: begin
        exp_q.push_back(mk(0, 1, 3'b100, 1, 0, 0, 0, 0, 2'b00));
        exp_q.push_back(mk(1, 0, 3'b010, 0, 1, 0, 0, 0, 2'b00));
      end
      4'd2, 4'd3: begin
        exp_q.push_back(mk(0, 1, 3'b100, 0, 0, 1, 0, 0, 2'b00));
        exp_q.push_back(mk(0, 1, 3'b101, 0, 0, 0, 1, 0, 2'b00));
        exp_q.push_back(mk(1, 0, 3'b010, 0, 0, 0, 0, 1,
                           (ins[15:12] == 4'd3) ? 2'b01 : 2'b00));
      end
      4'd4: begin
        exp_q.push_back(mk(0, 1, 3'b010, 1, 0, 0, 0, 0, 2'b00));
        exp_q.push_back(mk(0, 1, 3'b011, 0, 0, 1, 0, 0, 2'b00));
        exp_q.push_back(mk(1, 0, 3'b011, 0, 1, 0, 0, 0, 2'b00));
        exp_q.push_back(mk(1, 0, 3'b010, 0, 0, 0, 0, 1, 2'b10));
      end
      4'd5: begin
        exp_q.push_back(mk(0, 1, 3'b000, 1, 0, 0, 0, 0, 2'b00));
        exp_q.push_back(mk(1, 0, 3'b010, 0, 1, 0, 0, 0, 2'b00));
      end
      default: ;
    endcase
    d = '0;
    d.done = 1'b1;
    exp_q.push_back(d);
  endtask

  task automatic push_idle();
    rec_t r;
    r = '0;
    exp_q.push_back(r);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(1);
    tick(1);
    check(tag, exp_q.size(), 0);
  endtask

  task automatic run_one(input logic [15:0] ins);
    push_idle();
    expect_instr(ins);
    start = 1'b1;
    instr = ins;
    tick(1);
    start = 1'b0;
  endtask

  // Per-cycle compare against the scoreboard plus the bus-safety invariants.
  always @(negedge clk) begin
    if (!reset) begin
      mon_obs = {busy, done, GPR_in, GPR_out, GPR_select, TMP_in, TMP_out,
                 ALU_A_in, ALU_B_in, ALU_out, ALU_op};
      mon_exp = (exp_q.size() != 0) ? exp_q.pop_front() : rec_t'(0);
      check("cycle", 32'(mon_obs), 32'(mon_exp));
      check("inv_in_out", 32'(GPR_in & GPR_out), 0);
      check("inv_one_driver", 32'((32'(GPR_out) + 32'(TMP_out) + 32'(ALU_out)) <= 1), 1);
      check("inv_sel_idle", 32'(!GPR_in && !GPR_out && (GPR_select != 3'b000)), 0);
    end
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    instr = 16'h0000;
    #2;
    check("reset_outputs", {busy, done, GPR_in, GPR_out, GPR_select, TMP_in, TMP_out,
                            ALU_A_in, ALU_B_in, ALU_out, ALU_op}, 0);
    check("reset_fields", {Rd_1, Rd_2, Rs_1, Rs_2}, 0);
    check("reset_illegal", 32'(illegal_op), 0);
    tick(2);
    reset = 1'b0;
    tick(1);

    // ADD R3 <- R1 + R2, with a start pulse mid-operation that must be ignored.
    run_one(16'h260A);
    check("add_rd1", 32'(Rd_1), 3);
    check("add_rs1", 32'(Rs_1), 1);
    check("add_rs2", 32'(Rs_2), 2);
    tick(1);
    start = 1'b1;
    instr = 16'h1A20;
    tick(1);
    start = 1'b0;
    drain("add_drain");
    check("add_ignore_rd1", 32'(Rd_1), 3);
    tick(2);

    // Two MOVs with start held: second accepted in the first's done cycle.
    push_idle();
    expect_instr(16'h1A20);
    expect_instr(16'h1A20);
    start = 1'b1;
    instr = 16'h1A20;
    tick(4);
    start = 1'b0;
    drain("mov_b2b_drain");
    check("mov_rd1", 32'(Rd_1), 5);
    check("mov_rs1", 32'(Rs_1), 4);
    tick(2);

    // SWAP R2 <-> R6.
    run_one(16'h4580);
    check("swap_rd1", 32'(Rd_1), 2);
    check("swap_rd2", 32'(Rd_2), 6);
    drain("swap_drain");

    // SUB R7 <- R2 - R3, CLR R6, NOP.
    run_one(16'h3E53);
    check("sub_fields", {Rd_1, Rs_1, Rs_2}, {3'd7, 3'd2, 3'd3});
    drain("sub_drain");
    run_one(16'h5C00);
    drain("clr_drain");
    run_one(16'h0000);
    drain("nop_drain");

    // Reset during SWAP step 1: strobes drop at once, no done afterwards.
    run_one(16'h4580);
    tick(1);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("rst_mid_outputs", {busy, done, GPR_in, GPR_out, GPR_select, TMP_in, TMP_out,
                              ALU_A_in, ALU_B_in, ALU_out, ALU_op}, 0);
    tick(1);
    reset = 1'b0;
    tick(4);
    run_one(16'h1A20);
    drain("post_rst_mov_drain");

    // Undefined opcode: done next cycle, no strobes, trap flag if built in.
    check("ill_before", 32'(illegal_op), 0);
    run_one(16'hF000);
    check("ill_after", 32'(illegal_op), 32'(EXP_ILL));
    drain("ill_drain");
    check("ill_sticky", 32'(illegal_op), 32'(EXP_ILL));
    reset = 1'b1;
    #1;
    check("ill_reset_clear", 32'(illegal_op), 0);
    tick(1);
    reset = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
